// File: rtl/ysyx_22041461_mem_pkg.sv
// Shared types and widths for the cycle-accurate memory responder.
package ysyx_22041461_mem_pkg;

  localparam int DATA_W = 64;
  localparam int ADDR_W = 64;
  localparam int STRB_W = 8;

  localparam logic [ADDR_W-1:0] ADDR_BASE_DEFAULT = 64'h0000_0000_8000_0000;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_e;

endpackage

// File: rtl/ysyx_22041461_mem_array.sv
// Single-port DEPTH x 64 word storage: synchronous byte-masked write,
// combinational read of the addressed word.
module ysyx_22041461_mem_array
  import ysyx_22041461_mem_pkg::*;
#(
  parameter int DEPTH = 1024
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] idx,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [STRB_W-1:0]        wmask,
  output logic [DATA_W-1:0]        rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // NOTE: storage is deliberately left out of reset; contents survive rst and
  // a reset branch here would stop the array mapping onto RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (wmask[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/ysyx_22041461_mem_responder.sv
// Memory responder: one request at a time over valid/ready, answered after a
// fixed LATENCY of wait cycles, backed by byte-maskable word storage.
module ysyx_22041461_mem_responder
  import ysyx_22041461_mem_pkg::*;
#(
  parameter logic [ADDR_W-1:0] ADDR_BASE = ADDR_BASE_DEFAULT,
  parameter int                DEPTH     = 1024,
  parameter int                LATENCY   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [STRB_W-1:0] req_wmask,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err
);

  localparam int                IDX_W  = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] SPAN   = ADDR_W'(DEPTH) << 3;
  localparam logic [3:0]        CNT_LD = 4'((LATENCY == 0) ? 0 : LATENCY - 1);

  state_e state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic       enter_resp;

  logic              cap_we;
  logic [ADDR_W-1:0] cap_addr;
  logic [DATA_W-1:0] cap_wdata;
  logic [STRB_W-1:0] cap_wmask;

  logic              op_we;
  logic [ADDR_W-1:0] op_addr;
  logic [DATA_W-1:0] op_wdata;
  logic [STRB_W-1:0] op_wmask;
  logic [ADDR_W-1:0] op_off;
  logic              op_in_range;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);

  // NOTE: every combinational output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    enter_resp = 1'b0;
    unique case (state)
      IDLE: begin
        if (req_valid) begin
          if (LATENCY == 0) begin
            state_nxt  = RESP;
            enter_resp = 1'b1;
          end else begin
            state_nxt = WAIT;
            cnt_nxt   = CNT_LD;
          end
        end
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          state_nxt  = RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      RESP: begin
        if (resp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // With zero latency the operation happens on the accepting edge, before the
  // capture registers are loaded, so the live request is used instead.
  always_comb begin
    if (state == IDLE) begin
      op_we    = req_we;
      op_addr  = req_addr;
      op_wdata = req_wdata;
      op_wmask = req_wmask;
    end else begin
      op_we    = cap_we;
      op_addr  = cap_addr;
      op_wdata = cap_wdata;
      op_wmask = cap_wmask;
    end
  end

  assign op_off      = op_addr - ADDR_BASE;
  assign op_in_range = (op_addr >= ADDR_BASE) && (op_off < SPAN);
  assign mem_we      = enter_resp && op_we && op_in_range && !rst;

  ysyx_22041461_mem_array #(
    .DEPTH(DEPTH)
  ) u_array (
    .clk  (clk),
    .we   (mem_we),
    .idx  (op_off[IDX_W+2:3]),
    .wdata(op_wdata),
    .wmask(op_wmask),
    .rdata(mem_rdata)
  );

  // NOTE: all state below uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      cap_we     <= 1'b0;
      cap_addr   <= '0;
      cap_wdata  <= '0;
      cap_wmask  <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (req_valid && req_ready) begin
        cap_we    <= req_we;
        cap_addr  <= req_addr;
        cap_wdata <= req_wdata;
        cap_wmask <= req_wmask;
      end
      if (enter_resp) begin
        resp_err   <= !op_in_range;
        resp_rdata <= (op_we || !op_in_range) ? '0 : mem_rdata;
      end else if (resp_valid && resp_ready) begin
        resp_err   <= 1'b0;
        resp_rdata <= '0;
      end
    end
  end

endmodule

// File: tb/tb_ysyx_22041461_mem_responder.sv
// Self-checking bench: transaction-level memory model plus directed literal checks.
module tb_ysyx_22041461_mem_responder;
  import ysyx_22041461_mem_pkg::*;

  localparam logic [63:0] BASE  = 64'h0000_0000_8000_0000;
  localparam int          DEPTH = 1024;
  localparam int          LAT   = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        req_valid = 0, req_ready, req_we = 0, resp_valid, resp_ready = 0, resp_err;
  logic [63:0] req_addr = 0, req_wdata = 0, resp_rdata;
  logic [7:0]  req_wmask = 0;

  logic        z_req_valid = 0, z_req_ready, z_req_we = 0, z_resp_valid, z_resp_ready = 0, z_resp_err;
  logic [63:0] z_req_addr = 0, z_req_wdata = 0, z_resp_rdata;
  logic [7:0]  z_req_wmask = 0;

  ysyx_22041461_mem_responder #(.ADDR_BASE(BASE), .DEPTH(DEPTH), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  ysyx_22041461_mem_responder #(.ADDR_BASE(BASE), .DEPTH(16), .LATENCY(0)) dut_z (
    .clk(clk), .rst(rst), .req_valid(z_req_valid), .req_ready(z_req_ready), .req_we(z_req_we),
    .req_addr(z_req_addr), .req_wdata(z_req_wdata), .req_wmask(z_req_wmask),
    .resp_valid(z_resp_valid), .resp_ready(z_resp_ready), .resp_rdata(z_resp_rdata), .resp_err(z_resp_err)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [63:0] mdl_mem [DEPTH];
  int          cyc = 0;
  bit          pending = 0;
  int          due = 0;
  logic        m_we;
  logic [63:0] m_addr, m_wdata;
  logic [7:0]  m_mask;
  logic [63:0] exp_rdata = 0;
  logic        exp_err = 0;

  function automatic bit in_map(input logic [63:0] a);
    return (a >= BASE) && ((a - BASE) < 64'(DEPTH) * 64'd8);
  endfunction

  task automatic apply_op();
    int idx;
    if (!in_map(m_addr)) begin
      exp_err   = 1'b1;
      exp_rdata = '0;
    end else begin
      idx     = int'((m_addr - BASE) >> 3);
      exp_err = 1'b0;
      if (m_we) begin
        for (int b = 0; b < 8; b++)
          if (m_mask[b]) mdl_mem[idx][8*b +: 8] = m_wdata[8*b +: 8];
        exp_rdata = '0;
      end else begin
        exp_rdata = mdl_mem[idx];
      end
    end
  endtask

  // Response becomes visible LAT edges after acceptance; the op takes effect then.
  initial forever begin
    @(posedge clk);
    cyc++;
    if (rst) begin
      pending = 0;
    end else if (pending) begin
      if (cyc - 1 >= due && resp_ready) pending = 0;
      else if (cyc == due) apply_op();
    end else if (req_valid) begin
      pending = 1;
      m_we = req_we; m_addr = req_addr; m_wdata = req_wdata; m_mask = req_wmask;
      due = cyc + LAT;
      if (LAT == 0) apply_op();
    end
  end

  bit started = 0;
  initial forever begin
    logic ev;
    @(negedge clk);
    if (started) begin
      ev = pending && (cyc >= due);
      check("req_ready", {63'd0, req_ready}, {63'd0, !pending});
      check("resp_valid", {63'd0, resp_valid}, {63'd0, ev});
      if (ev) begin
        check("resp_rdata", resp_rdata, exp_rdata);
        check("resp_err", {63'd0, resp_err}, {63'd0, exp_err});
      end
    end
  end

  // ---------------- driver ----------------
  task automatic do_req(input logic we, input logic [63:0] addr, input logic [63:0] wdata,
                        input logic [7:0] mask, input int hold,
                        output logic [63:0] rd, output logic err, output int lat);
    int a;
    int waited;
    bit seen;
    rd = '0; err = 1'b0; lat = -1;
    @(negedge clk);
    waited = 0;
    while (!req_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!req_ready) begin
      check("req_ready_timeout", {63'd0, req_ready}, 64'd1);
      return;
    end
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_wmask = mask;
    @(posedge clk);
    #1 a = cyc;
    seen = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      // busy-time inputs must be ignored
      req_we = 1'($urandom); req_addr = {$urandom, $urandom};
      req_wdata = {$urandom, $urandom}; req_wmask = 8'($urandom);
      if (resp_valid) begin
        if (!seen) begin
          seen = 1; rd = resp_rdata; err = resp_err; lat = cyc - a;
        end else begin
          check("hold_rdata", resp_rdata, rd);
          check("hold_err", {63'd0, resp_err}, {63'd0, err});
        end
        if (hold > 0) begin
          resp_ready = 1'b0;
          hold--;
        end else begin
          resp_ready = 1'b1;
          req_valid  = 1'b0;
          break;
        end
      end else begin
        resp_ready = 1'($urandom);
      end
    end
    if (!seen) check("resp_timeout", {63'd0, resp_valid}, 64'd1);
    @(posedge clk);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, total=%0d", total);
    $fatal(1);
  end

  initial begin
    logic [63:0] rd;
    logic        err;
    int          lat;
    logic [63:0] addr;
    int          r;
    logic [7:0]  mask;

    // reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", {63'd0, req_ready}, 64'd1);
    check("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
    check("rst_resp_rdata", resp_rdata, 64'd0);
    check("rst_resp_err", {63'd0, resp_err}, 64'd0);
    started = 1;
    rst = 1'b0;

    // give the words used below defined contents
    for (int i = 0; i < 16; i++)
      do_req(1'b1, BASE + 64'(8 * i), {$urandom, $urandom}, 8'hFF, 0, rd, err, lat);
    do_req(1'b1, BASE + 64'h20, 64'hDEAD_BEEF_0BAD_F00D, 8'hFF, 0, rd, err, lat);
    do_req(1'b1, BASE, 64'h0123_4567_89AB_CDEF, 8'hFF, 0, rd, err, lat);
    do_req(1'b1, BASE + 64'h1FF8, 64'h5A5A_0000_FFFF_A5A5, 8'hFF, 0, rd, err, lat);

    // full write then read
    do_req(1'b1, 64'h8000_0010, 64'h1122_3344_5566_7788, 8'hFF, 0, rd, err, lat);
    check("wr_latency", 64'(lat), 64'(LAT));
    check("wr_err", {63'd0, err}, 64'd0);
    check("wr_rdata_zero", rd, 64'd0);
    do_req(1'b0, 64'h8000_0010, 64'd0, 8'h00, 0, rd, err, lat);
    check("rd_full", rd, 64'h1122_3344_5566_7788);
    check("rd_latency", 64'(lat), 64'(LAT));

    // partial write; offset 4 indexes the same word
    do_req(1'b1, 64'h8000_0010, 64'hFFFF_FFFF_AAAA_BBBB, 8'h0F, 0, rd, err, lat);
    do_req(1'b0, 64'h8000_0014, 64'd0, 8'h00, 0, rd, err, lat);
    check("rd_partial", rd, 64'h1122_3344_AAAA_BBBB);
    do_req(1'b1, 64'h8000_0010, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, 0, rd, err, lat);
    do_req(1'b0, 64'h8000_0010, 64'd0, 8'h00, 0, rd, err, lat);
    check("rd_mask0", rd, 64'h1122_3344_AAAA_BBBB);

    // out of range on both sides, plus the last mapped word
    do_req(1'b0, 64'h7FFF_FFF8, 64'd0, 8'h00, 0, rd, err, lat);
    check("oor_low_err", {63'd0, err}, 64'd1);
    check("oor_low_rdata", rd, 64'd0);
    check("oor_latency", 64'(lat), 64'(LAT));
    do_req(1'b0, 64'h8000_2000, 64'd0, 8'h00, 0, rd, err, lat);
    check("oor_high_err", {63'd0, err}, 64'd1);
    do_req(1'b1, 64'h8000_2000, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 0, rd, err, lat);
    check("oor_wr_err", {63'd0, err}, 64'd1);
    do_req(1'b1, 64'h7FFF_FFF8, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 0, rd, err, lat);
    do_req(1'b0, 64'h8000_0000, 64'd0, 8'h00, 0, rd, err, lat);
    check("oor_base_kept", rd, 64'h0123_4567_89AB_CDEF);
    do_req(1'b0, 64'h8000_1FF8, 64'd0, 8'h00, 0, rd, err, lat);
    check("last_word_err", {63'd0, err}, 64'd0);
    check("last_word_kept", rd, 64'h5A5A_0000_FFFF_A5A5);

    // backpressure for 5 cycles
    do_req(1'b0, 64'h8000_0010, 64'd0, 8'h00, 5, rd, err, lat);
    check("bp_rdata", rd, 64'h1122_3344_AAAA_BBBB);

    // reset during the first wait cycle of a write
    @(negedge clk);
    check("midop_idle", {63'd0, req_ready}, 64'd1);
    req_valid = 1'b1; req_we = 1'b1; req_addr = BASE + 64'h20;
    req_wdata = 64'hFFFF_FFFF_FFFF_FFFF; req_wmask = 8'hFF;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1; req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("midop_no_resp", {63'd0, resp_valid}, 64'd0);
    end
    do_req(1'b0, BASE + 64'h20, 64'd0, 8'h00, 0, rd, err, lat);
    check("midop_kept", rd, 64'hDEAD_BEEF_0BAD_F00D);

    // randomized traffic against the model
    for (int n = 0; n < 150; n++) begin
      r = $urandom_range(0, 9);
      if (r == 0)      addr = BASE - 64'(8 * $urandom_range(1, 4)) + 64'($urandom_range(0, 7));
      else if (r == 1) addr = BASE + 64'(8 * DEPTH) + 64'(8 * $urandom_range(0, 3)) + 64'($urandom_range(0, 7));
      else             addr = BASE + 64'(8 * $urandom_range(0, 15)) + 64'($urandom_range(0, 7));
      r = $urandom_range(0, 7);
      mask = (r == 0) ? 8'h00 : (r == 1) ? 8'hFF : 8'($urandom);
      do_req(1'($urandom), addr, {$urandom, $urandom}, mask, $urandom_range(0, 3), rd, err, lat);
    end

    // zero-latency build: response on the cycle after the request
    @(negedge clk);
    z_req_valid = 1'b1; z_req_we = 1'b1; z_req_addr = BASE + 64'h8;
    z_req_wdata = 64'hCAFE_F00D_1234_5678; z_req_wmask = 8'hFF; z_resp_ready = 1'b0;
    @(posedge clk);
    #1;
    check("z_wr_valid", {63'd0, z_resp_valid}, 64'd1);
    check("z_wr_ready", {63'd0, z_req_ready}, 64'd0);
    check("z_wr_rdata", z_resp_rdata, 64'd0);
    @(negedge clk);
    z_req_valid = 1'b0; z_resp_ready = 1'b1;
    @(posedge clk);
    #1;
    check("z_idle_valid", {63'd0, z_resp_valid}, 64'd0);
    check("z_idle_ready", {63'd0, z_req_ready}, 64'd1);
    @(negedge clk);
    z_req_valid = 1'b1; z_req_we = 1'b0;
    @(posedge clk);
    #1;
    check("z_rd_valid", {63'd0, z_resp_valid}, 64'd1);
    check("z_rd_rdata", z_resp_rdata, 64'hCAFE_F00D_1234_5678);
    @(negedge clk);
    z_req_addr = BASE + 64'h80;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("z_oor_valid", {63'd0, z_resp_valid}, 64'd1);
    check("z_oor_err", {63'd0, z_resp_err}, 64'd1);
    @(negedge clk);
    z_req_valid = 1'b0;
    repeat (2) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
